// File: rtl/fetch_stage.sv
// Instruction fetch stage: holds the PC, keeps at most one request outstanding to a
// variable-latency instruction memory, and presents one instruction at a time to decode.
module fetch_stage #(
    parameter logic [15:0] PC_RESET = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_rdy,
    input  logic [15:0] imem_data,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic [15:0] instr,
    output logic [15:0] pc_plus2,
    output logic [4:0]  opCode,
    output logic [1:0]  funct,
    output logic        valid,
    output logic        halted
);

    typedef enum logic {FETCH, HALTED} state_t;

    state_t      state, state_nxt;
    logic [15:0] pc;
    logic        pending;
    logic        accept;
    logic        consume;

    always_ff @(posedge clk) begin
        if (rst) state <= FETCH;
        else     state <= state_nxt;
    end

    // A held request must stay up until rdy; otherwise only ask when the slot
    // is empty or being drained this cycle.
    always_comb begin
        state_nxt = state;
        imem_req  = 1'b0;
        accept    = 1'b0;
        consume   = valid && !stall;
        if (state == FETCH) begin
            imem_req = !rst && !redirect && (pending || !valid || !stall);
            accept   = imem_req && imem_rdy;
            if (accept && (imem_data[15:11] == 5'b00000))
                state_nxt = HALTED;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc       <= PC_RESET;
            instr    <= 16'h0000;
            pc_plus2 <= 16'h0000;
            valid    <= 1'b0;
            pending  <= 1'b0;
        end else if (redirect) begin
            // Squash both the presented slot and anything in flight.
            pc      <= redirect_pc;
            valid   <= 1'b0;
            pending <= 1'b0;
        end else if (accept) begin
            instr    <= imem_data;
            pc_plus2 <= pc + 16'd2;
            valid    <= 1'b1;
            pc       <= pc + 16'd2;
            pending  <= 1'b0;
        end else begin
            if (imem_req) pending <= 1'b1;
            if (consume)  valid   <= 1'b0;
        end
    end

    assign imem_addr = pc;
    assign opCode    = instr[15:11];
    assign funct     = instr[1:0];
    assign halted    = (state == HALTED);

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage directly upstream of the decode/ALU-control path. It holds the PC and fetches 16-bit instructions over a req/rdy handshake from a variable-latency instruction memory. It presents each instruction with its `opCode`/`funct` fields and `valid` to the downstream decode stage, which drives `alu_cntrl`. It supports downstream stall, PC redirect for branches and jumps, and stops fetching on HALT.

## Interface
- `PC_RESET`, 16'h0000, PC value loaded on reset.

- `clk` in 1: single clock, all state on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `imem_req` out 1: fetch request to instruction memory.
- `imem_addr` out 16: fetch address. Equals current PC.
- `imem_rdy` in 1: memory response valid. Meaningful only while `imem_req`=1.
- `imem_data` in 16: instruction word. Sampled when `imem_req && imem_rdy`.
- `stall` in 1: downstream cannot accept this cycle.
- `redirect` in 1: load new PC and squash the fetched and in-flight instruction.
- `redirect_pc` in 16: target PC, used when `redirect`=1.
- `instr` out 16: registered instruction.
- `pc_plus2` out 16: address of `instr` + 2, for branch targets and link.
- `opCode` out 5: `instr[15:11]`, combinational from the `instr` register.
- `funct` out 2: `instr[1:0]`, combinational from the `instr` register.
- `valid` out 1: `instr` holds a live instruction.
- `halted` out 1: a HALT (opCode 5'b00000) has been fetched and fetching has stopped.

## Operation
- State: `pc` (16), output slot (`instr`, `pc_plus2`, `valid`), `pending` (a request is outstanding), FSM {FETCH, HALTED}.
- Consume: the slot is consumed in any cycle with `valid && !stall`.
- Issue: in FETCH, `imem_req` = `pending || (!valid || !stall)`. It is forced to 0 in HALTED, during `rst`, and in any cycle with `redirect`=1.
- Request hold: once `imem_req` is raised without `imem_rdy`, `pending` is set. `imem_req` and `imem_addr` then stay stable until `imem_rdy`, regardless of `stall`. Only `redirect` or `rst` may drop `imem_req` early.
- Accept (`imem_req && imem_rdy`, no redirect):
  - `instr` <= `imem_data`, `pc_plus2` <= `pc`+2, `valid` <= 1, `pc` <= `pc`+2, `pending` <= 0.
- Consume without accept: `valid` <= 0.
- HALT: if the accepted word has `imem_data[15:11]`=5'b00000, the FSM goes to HALTED. The HALT word is still presented with `valid`=1 until consumed. `halted`=1 from the cycle after the accept. No further requests are issued.
- Redirect has highest priority after `rst`:
  - `pc` <= `redirect_pc`, `valid` <= 0, `pending` <= 0.
  - `imem_rdy`/`imem_data` in the same cycle are ignored.
  - Fetch from the new PC starts the next cycle.
  - In HALTED, redirect updates `pc` but does not leave HALTED. Only `rst` exits HALTED.
- PC arithmetic: 16-bit, wraps modulo 2^16 (16'hFFFE + 2 = 16'h0000). There is no alignment check; bit 0 of `redirect_pc` is passed through.

## Timing
- Reset values:
  - `pc`=`PC_RESET`, `imem_addr`=`PC_RESET`.
  - `imem_req`=0, `valid`=0, `instr`=0, `opCode`=0, `funct`=0, `pc_plus2`=0, `halted`=0, `pending`=0, FSM=FETCH.
- `rst` asserted mid-request abandons the request. Memory must tolerate `imem_req` dropping.
- First `imem_req`=1 occurs in the first cycle with `rst`=0.
- Zero-wait memory (`imem_rdy` in the same cycle as `imem_req`): `valid` rises 1 cycle after the first request. Throughput is then 1 instruction/cycle while `stall`=0.
- N-cycle memory latency adds N cycles per instruction. There is no prefetch beyond one outstanding request.
- While `valid && stall`, all outputs hold, and no new request is issued unless `pending`.
- Simultaneous consume and accept: the slot is replaced in the same edge, and `valid` stays 1.

## Test plan
- Zero-wait memory returns word = 16'h4000 | addr, `PC_RESET`=0, no stall → `imem_addr` 0,2,4,6 on consecutive cycles; `instr` 16'h4000,16'h4002,… with `valid`=1 every cycle; `pc_plus2` 2,4,6.
- `stall` held 3 cycles while `instr`=16'h4002 → `instr`, `valid` and `pc_plus2` unchanged; `imem_req`=0; the next instruction (addr 4) appears the cycle after `stall` drops.
- Memory with 3-cycle latency, `stall` pulsed mid-wait → `imem_req` and `imem_addr` stay constant until `imem_rdy`; one instruction accepted every 4 cycles.
- `redirect`=1 with `redirect_pc`=16'h0100 in the same cycle as `imem_rdy` → returned word dropped; `valid`=0 next cycle; next `imem_addr`=16'h0100.
- Memory returns 16'h0000 at addr 6 → `valid`=1 with `opCode`=0 until consumed; `halted`=1 from the next cycle; `imem_req` stays 0 for 10 cycles; a redirect does not restart fetch; `rst` restarts fetch at `PC_RESET`.
- `redirect_pc`=16'hFFFE → fetches 16'hFFFE then 16'h0000; `pc_plus2` for the first = 16'h0000.
